// File: rtl/cmd_scheduler.sv
// SD command scheduler: serialises SW commands, Auto CMD12 and Auto CMD23 onto one command engine
// and routes completion/error status back to the owner. Auto CMD23 sequencing: SDHCI_AUTO_CMD23_EN.
package sdhci_pkg;
  typedef enum logic [2:0] {
    NO_RESPONSE = 3'd0,
    RSP_R1      = 3'd1,
    RSP_R1B     = 3'd2,
    RSP_R2      = 3'd3,
    RSP_R3      = 3'd4
  } response_type_e;
endpackage

module cmd_scheduler
  import sdhci_pkg::*;
#(
  parameter logic [31:0] CMD12_ARG = 32'h0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           cmd_line_rst_i,
  input  logic           sw_valid_i,
  output logic           sw_ready_o,
  input  logic [5:0]     sw_cmd_i,
  input  logic [31:0]    sw_arg_i,
  input  response_type_e sw_rsp_type_i,
  input  logic           sw_auto23_i,
  input  logic [15:0]    blk_cnt_i,
  input  logic           auto12_req_i,
  output logic           cmd_valid_o,
  input  logic           cmd_ready_i,
  output logic [5:0]     cmd_o,
  output logic [31:0]    cmd_arg_o,
  output response_type_e rsp_type_o,
  input  logic           cmd_done_i,
  input  logic           result_valid_i,
  input  logic           timeout_err_i,
  input  logic           index_err_i,
  input  logic           end_bit_err_i,
  input  logic           crc_err_i,
  output logic           cmd_inhibit_o,
  output logic           sw_complete_o,
  output logic [3:0]     sw_err_o,
  output logic           auto_complete_o,
  output logic [4:0]     auto_err_o,
  input  logic           auto_err_clear_i,
  output logic           rsp_owner_auto_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  typedef enum logic [1:0] {OWN_SW, OWN_A12, OWN_A23} owner_e;

  state_e         state_q, state_d;
  owner_e         owner_q;
  logic [5:0]     cmd_q;
  logic [31:0]    arg_q;
  response_type_e rsp_q;

  logic           sw_pend_q;
  logic [5:0]     sw_cmd_q;
  logic [31:0]    sw_arg_q;
  response_type_e sw_rsp_q;
  logic           a12_pend_q;

  logic           sw_complete_q;
  logic [3:0]     sw_err_q;
  logic           auto_complete_q;
  logic [4:0]     auto_err_q;
  logic [4:0]     auto_err_set;

  logic           sw_accept;
  logic           wait_end;
  logic [3:0]     end_err;
  logic           a23_failed;
  logic           want_a23;
  logic [31:0]    a23_arg;
  logic           start_a12, start_a23, start_sw;

  assign sw_ready_o = (state_q == IDLE) && !sw_pend_q;
  assign sw_accept  = sw_valid_i && sw_ready_o && !cmd_line_rst_i;

  // Checks only mean something alongside a response; timeout stands on its own.
  assign end_err    = {result_valid_i & index_err_i, result_valid_i & end_bit_err_i,
                       result_valid_i & crc_err_i, timeout_err_i};
  assign a23_failed = |end_err;
  assign wait_end   = !cmd_line_rst_i && (state_q == WAIT) &&
                      (result_valid_i || timeout_err_i || (cmd_done_i && rsp_q == NO_RESPONSE));

`ifdef SDHCI_AUTO_CMD23_EN
  logic        sw_auto23_q;
  logic [15:0] a23_blk_q;
  logic        a23_done_q;

  // a23_done marks that the latched SW command already had its CMD23 sent cleanly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_auto23_q <= 1'b0;
      a23_blk_q   <= '0;
      a23_done_q  <= 1'b0;
    end else if (cmd_line_rst_i) begin
      a23_done_q  <= 1'b0;
    end else if (sw_accept) begin
      sw_auto23_q <= sw_auto23_i;
      a23_blk_q   <= blk_cnt_i;
      a23_done_q  <= 1'b0;
    end else if (wait_end && owner_q == OWN_A23 && !a23_failed) begin
      a23_done_q  <= 1'b1;
    end
  end

  assign want_a23 = sw_auto23_q && !a23_done_q;
  assign a23_arg  = {16'h0, a23_blk_q};
`else
  logic unused_a23;
  assign unused_a23 = ^{sw_auto23_i, blk_cnt_i};
  assign want_a23   = 1'b0;
  assign a23_arg    = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_a12 = 1'b0;
    start_a23 = 1'b0;
    start_sw  = 1'b0;
    if (cmd_line_rst_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (a12_pend_q) begin
            start_a12 = 1'b1;
            state_d   = ISSUE;
          end else if (sw_pend_q && want_a23) begin
            start_a23 = 1'b1;
            state_d   = ISSUE;
          end else if (sw_pend_q) begin
            start_sw  = 1'b1;
            state_d   = ISSUE;
          end
        end
        ISSUE:   if (cmd_ready_i) state_d = WAIT;
        WAIT:    if (wait_end) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A failed CMD23 retires the SW command unissued; the SW owner still sees a clean completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q         <= OWN_SW;
      cmd_q           <= '0;
      arg_q           <= '0;
      rsp_q           <= NO_RESPONSE;
      sw_pend_q       <= 1'b0;
      sw_cmd_q        <= '0;
      sw_arg_q        <= '0;
      sw_rsp_q        <= NO_RESPONSE;
      a12_pend_q      <= 1'b0;
      sw_complete_q   <= 1'b0;
      sw_err_q        <= '0;
      auto_complete_q <= 1'b0;
    end else begin
      sw_complete_q   <= 1'b0;
      auto_complete_q <= 1'b0;
      if (cmd_line_rst_i) begin
        sw_pend_q  <= 1'b0;
        a12_pend_q <= 1'b0;
      end else begin
        if (start_a12)         a12_pend_q <= 1'b0;
        else if (auto12_req_i) a12_pend_q <= 1'b1;
        if (sw_accept) begin
          sw_pend_q <= 1'b1;
          sw_cmd_q  <= sw_cmd_i;
          sw_arg_q  <= sw_arg_i;
          sw_rsp_q  <= sw_rsp_type_i;
        end
        if (start_a12) begin
          owner_q <= OWN_A12;
          cmd_q   <= 6'd12;
          arg_q   <= CMD12_ARG;
          rsp_q   <= RSP_R1B;
        end else if (start_a23) begin
          owner_q <= OWN_A23;
          cmd_q   <= 6'd23;
          arg_q   <= a23_arg;
          rsp_q   <= RSP_R1;
        end else if (start_sw) begin
          owner_q <= OWN_SW;
          cmd_q   <= sw_cmd_q;
          arg_q   <= sw_arg_q;
          rsp_q   <= sw_rsp_q;
        end
        if (wait_end) begin
          if (owner_q == OWN_SW) begin
            sw_complete_q <= 1'b1;
            sw_err_q      <= end_err;
            sw_pend_q     <= 1'b0;
          end else begin
            auto_complete_q <= 1'b1;
            if (owner_q == OWN_A23 && a23_failed) begin
              sw_complete_q <= 1'b1;
              sw_err_q      <= '0;
              sw_pend_q     <= 1'b0;
            end
          end
        end
      end
    end
  end

  // A new error in the same cycle as a clear survives the clear.
  assign auto_err_set = (wait_end && owner_q != OWN_SW) ?
                        {(owner_q == OWN_A23) && a23_failed, end_err} : 5'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) auto_err_q <= '0;
    else         auto_err_q <= (auto_err_clear_i ? 5'b0 : auto_err_q) | auto_err_set;
  end

  assign cmd_valid_o      = (state_q == ISSUE);
  assign cmd_o            = cmd_q;
  assign cmd_arg_o        = arg_q;
  assign rsp_type_o       = rsp_q;
  assign cmd_inhibit_o    = (state_q != IDLE) || sw_pend_q || a12_pend_q;
  assign sw_complete_o    = sw_complete_q;
  assign sw_err_o         = sw_err_q;
  assign auto_complete_o  = auto_complete_q;
  assign auto_err_o       = auto_err_q;
  assign rsp_owner_auto_o = (state_q == WAIT) && (owner_q != OWN_SW);

endmodule
